start_din_conditioner: RTL
==========================

Name: start_din_conditioner

Overview:
- Input-side counterpart to the seven-segment output path: turns raw board switches into the clean `start`/`din` request consumed by the `asm_ex` datapath.
- Synchronizes and debounces the start switch, emits a single-cycle `start_tick` on each debounced rising edge, and captures and holds `din`.
- Tracks a busy/done handshake with the datapath, so presses arriving during an operation are dropped.
- Instantiated in the top level between `sw` and `asm_ex`.

Parameters:
- N_BITS, 20, debounce counter width; stable interval = 2^N_BITS clocks (~10.5 ms at 100 MHz).
- DIN_W, 4, width of captured data field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw  input  DIN_W+1  raw switches; sw[DIN_W] = start switch, sw[DIN_W-1:0] = data.
- done_tick  input  1  one-cycle completion pulse from datapath.
- start_tick  output  1  one-cycle request pulse to datapath.
- din  output  DIN_W  data captured with the accepted start_tick; held until the next accepted start.
- busy  output  1  high from an accepted start until done_tick.
- db_level  output  1  debounced level of the start switch (for LED).

Behaviour:
- Reset (reset=0, async): state=ZERO, counter=0, sync regs=0, start_tick=0, din=0, busy=0, db_level=0.
- Synchronizer:
  - Two flops on every sw bit.
  - s2 = sw delayed 2 clocks.
  - All FSM/data logic uses s2 only.
- Debounce FSM (states ZERO, WAIT1, ONE, WAIT0):
  - ZERO: s2=1 -> WAIT1, counter <= all ones; else stay.
  - WAIT1: s2=0 -> ZERO; else if counter==0 -> ONE (debounced rise); else counter--.
  - ONE: s2=0 -> WAIT0, counter <= all ones; else stay.
  - WAIT0: s2=1 -> ONE; else if counter==0 -> ZERO; else counter--.
  - db_level = 1 in ONE and WAIT0, 0 in ZERO and WAIT1 (registered from state).
- Rise latency:
  - A clean 0->1 on sw[DIN_W] held steady reaches ONE on the (2^N_BITS + 3)th rising clk edge after the edge that first samples it.
  - Fall latency is symmetric.
- Glitch rejection: any s2 reversal inside WAIT1/WAIT0 aborts back to the prior stable state; the counter reloads on the next attempt.
- Start acceptance:
  - start_tick is registered and asserts for exactly one cycle, on the edge where the FSM enters ONE from WAIT1, iff busy=0 before that edge.
  - On that same edge: din <= s2[DIN_W-1:0], busy <= 1.
  - WAIT0->ONE re-entry (bounce on release) never generates a tick.
- Busy:
  - Cleared on the edge after done_tick=1 is sampled.
  - done_tick while busy=0 is ignored.
- Simultaneous debounced rise and done_tick:
  - Gating uses the pre-edge busy value, so the press is dropped and busy ends 0.
  - No tick is stored or retried.
- Rise while busy: dropped; din unchanged; a tick requires release plus a new press.
- Reset mid-operation:
  - All state clears immediately.
  - If the start switch is still high after reset release, a full debounce runs and one start_tick fires.
- din never changes except on an accepted start.

Decomposition:
- Shared header/package holds:
  - FSM state codes (ZERO=2'b00, WAIT1=2'b01, ONE=2'b10, WAIT0=2'b11).
  - Default N_BITS and DIN_W constants.
- One natural sub-module: `debounce_fsm` (sync'd 1-bit in, db_level and rise_tick out, N_BITS parameter).
- The top handles the synchronizer, din capture and busy logic.

Test Plan (N_BITS=3, so 8-clock stable window):
- Reset held low with sw=5'h1F -> all outputs 0.
  - Release reset, keep sw=5'h1F -> start_tick pulses once at edge 11, din=4'hF, busy=1, db_level=1.
- From idle, sw[3:0]=4'hA, then sw[4] 0->1 steady -> single start_tick 11 clocks later, din=4'hA.
  - Then done_tick pulse -> busy=0 next cycle.
- sw[4] pulses high for 5 clocks, then low -> no start_tick, state returns ZERO, db_level stays 0.
  - Repeat with bounces (1,0,1 at 2-clock spacing, then steady 1) -> exactly one tick, 11 clocks after the last 0->1.
- While busy=1, release and re-press sw[4] with sw[3:0]=4'h3 -> no tick, din stays 4'hA.
  - done_tick, then a new press -> tick with din=4'h3.
- Align done_tick with the WAIT1->ONE edge -> no start_tick, busy=0 afterward.
- Assert reset during WAIT1 (counter=4) -> outputs cleared immediately.
  - Release with sw[4]=1 -> tick 11 clocks after release.

Source files
------------

// File: rtl/start_din_conditioner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// start_din_conditioner_pkg: shared debounce state codes and default sizes.
// Rev 1.0
// ---------------------------------------------------------------------------
package start_din_conditioner_pkg;

  localparam int N_BITS_DEF = 20;
  localparam int DIN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

endpackage
`default_nettype wire

// File: rtl/start_din_conditioner_debounce_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_fsm: debounces one synchronized level; flags the debounced rise.
// Rev 1.0
// ---------------------------------------------------------------------------
module debounce_fsm
  import start_din_conditioner_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic level_i,
  output logic db_level_o,
  output logic rise_o
);

  localparam logic [N_BITS-1:0] C_CNT_ONE = {{(N_BITS-1){1'b0}}, 1'b1};

  db_state_e         state_q;
  logic [N_BITS-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ZERO;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ZERO: begin
          if (level_i) begin
            state_q <= WAIT1;
            cnt_q   <= '1;
          end
        end
        WAIT1: begin
          if (!level_i)          state_q <= ZERO;
          else if (cnt_q == '0)  state_q <= ONE;
          else                   cnt_q   <= cnt_q - C_CNT_ONE;
        end
        ONE: begin
          if (!level_i) begin
            state_q <= WAIT0;
            cnt_q   <= '1;
          end
        end
        WAIT0: begin
          if (level_i)           state_q <= ONE;
          else if (cnt_q == '0)  state_q <= ZERO;
          else                   cnt_q   <= cnt_q - C_CNT_ONE;
        end
        default: state_q <= ZERO;
      endcase
    end
  end

  // Asserted during the cycle whose closing edge moves WAIT1 -> ONE.
  assign rise_o     = (state_q == WAIT1) && level_i && (cnt_q == '0);
  assign db_level_o = state_q[1];

endmodule
`default_nettype wire

// File: rtl/start_din_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// start_din_conditioner: sync/debounce start switch, capture din, track busy.
// Rev 1.0
// ---------------------------------------------------------------------------
module start_din_conditioner
  import start_din_conditioner_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int DIN_W  = DIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIN_W:0]   sw,
  input  logic             done_tick,
  output logic             start_tick,
  output logic [DIN_W-1:0] din,
  output logic             busy,
  output logic             db_level
);

  logic [DIN_W:0]   s1_q, s2_q;
  logic             start_tick_q, start_tick_d;
  logic             busy_q, busy_d;
  logic [DIN_W-1:0] din_q, din_d;
  logic             rise;

  debounce_fsm #(
    .N_BITS (N_BITS)
  ) u_debounce (
    .clk_i      (clk),
    .reset_ni   (reset),
    .level_i    (s2_q[DIN_W]),
    .db_level_o (db_level),
    .rise_o     (rise)
  );

  // Acceptance is gated on pre-edge busy, so a rise coinciding with
  // done_tick is dropped rather than queued.
  always_comb begin
    start_tick_d = rise && !busy_q;
    din_d        = start_tick_d ? s2_q[DIN_W-1:0] : din_q;
    busy_d       = busy_q;
    if (start_tick_d)   busy_d = 1'b1;
    else if (done_tick) busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      start_tick_q <= 1'b0;
      busy_q       <= 1'b0;
      din_q        <= '0;
    end else begin
      s1_q         <= sw;
      s2_q         <= s1_q;
      start_tick_q <= start_tick_d;
      busy_q       <= busy_d;
      din_q        <= din_d;
    end
  end

  assign start_tick = start_tick_q;
  assign busy       = busy_q;
  assign din        = din_q;

endmodule
`default_nettype wire
